stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter IF_LAT, default 1, meaning IF_WAIT dwell in cycles (legal 1..15).
REQ-002 SHALL have parameter MEM_LAT, default 1, meaning MEM_WAIT dwell in cycles (legal 1..15).
REQ-003 SHALL have parameter CNT_W, default 32, meaning perf counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port halt  input  1  halt request, sampled only in WB.
REQ-007 SHALL have port resume  input  1  leave HALT, sampled only in HALT.
REQ-008 SHALL have outputs pc_wren, wb_if_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren  output  1 each  per-stage write enables.
REQ-009 SHALL have port stage_reset_n  output  1  active-low per-instruction datapath clear.
REQ-010 SHALL have port stage  output  4  current state code.
REQ-011 SHALL have port halted  output  1  high while in HALT.
REQ-012 SHALL have ports cycle_cnt, instr_cnt  output  CNT_W each  performance counters.

Function
REQ-013 SHALL implement states INIT=0, IF=1, IF_WAIT=2, ID=3, EX=4, MEM=5, MEM_WAIT=6, WB=7, HALT=8; codes 9..15 illegal.
REQ-014 SHALL transition INIT->IF, IF->IF_WAIT, ID->EX, EX->MEM, MEM->MEM_WAIT unconditionally, one cycle each.
REQ-015 SHALL hold IF_WAIT for exactly IF_LAT cycles, then go to ID; SHALL hold MEM_WAIT for exactly MEM_LAT cycles, then go to WB; a 4-bit wait counter loads on entry and counts down.
REQ-016 SHALL go WB->HALT when halt=1 in WB, else WB->IF.
REQ-017 SHALL stay in HALT until resume=1, then go HALT->IF; resume outside HALT SHALL be ignored; halt=1 with resume=1 in HALT SHALL go to IF.
REQ-018 SHALL go to INIT on the next edge from any illegal state code.
REQ-019 SHALL decode outputs from the state register only (Moore; no input-to-output paths).
REQ-020 SHALL drive all eight wrens to 0 and stage_reset_n to 0 in INIT and HALT; halted=1 only in HALT.
REQ-021 SHALL set stage_reset_n=1 in IF, IF_WAIT, ID, EX, MEM, MEM_WAIT and 0 in WB.
REQ-022 SHALL assert if_id_wren only in the final IF_WAIT cycle and mem_wb_wren only in the final MEM_WAIT cycle.
REQ-023 SHALL assert id_ex_wren in ID, ex_mem_wren in EX, pc_wren and ram_wren in MEM, wb_if_wren and reg_wren in WB, each for one cycle per instruction.
REQ-024 SHALL produce an instruction period of 5+IF_LAT+MEM_LAT cycles, IF to IF, when halt=0.
REQ-025 SHALL assert at most one of if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, reg_wren in any cycle.

Reset
REQ-026 SHALL, while reset=1, asynchronously force state=INIT, wait counter=0, cycle_cnt=0, instr_cnt=0, and outputs to INIT values.
REQ-027 SHALL, on reset assertion mid-instruction (any state), abandon the instruction immediately with no further wren pulses.
REQ-028 SHALL leave INIT for IF on the first rising clk edge after reset deasserts.

Configuration
REQ-029 SHALL compile perf counters only when STAGE_SEQ_PERF_CNT_EN is defined.
REQ-030 SHALL, with STAGE_SEQ_PERF_CNT_EN, increment cycle_cnt every cycle not in INIT or HALT and instr_cnt on every WB cycle; both wrap modulo 2^CNT_W.
REQ-031 SHALL, without STAGE_SEQ_PERF_CNT_EN, tie cycle_cnt and instr_cnt to constant 0 with no counter flops.

Verification
REQ-032 SHALL cover IF_LAT=1, MEM_LAT=1, halt=0: reset release -> stage 0,1,2,3,4,5,6,7,1,...; period 7; if_id_wren at stage 2, mem_wb_wren at stage 6.
REQ-033 SHALL cover IF_LAT=3, MEM_LAT=4: IF_WAIT lasts 3 cycles with if_id_wren only in the 3rd; MEM_WAIT lasts 4 with mem_wb_wren only in the 4th; period 12.
REQ-034 SHALL cover halt=1 in WB: next stage=8, halted=1, all wrens 0; resume=0 for 5 cycles -> remains 8; resume=1 -> stage=1 next cycle.
REQ-035 SHALL cover reset=1 asserted between edges during MEM: outputs go to INIT values without a clock edge, no pc_wren/ram_wren pulse; after release, INIT then IF.
REQ-036 SHALL cover STAGE_SEQ_PERF_CNT_EN defined, 10 instructions at IF_LAT=MEM_LAT=1 then halt: instr_cnt=10, cycle_cnt=70, both frozen in HALT; undefined -> both read 0.
REQ-037 SHALL cover forcing state=12: next edge -> stage 0, then 1.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction sequencer. Walks the fetch/decode/
// execute/memory/writeback stages, emits one write enable per stage and
// parks in HALT on request.
// Optional feature macro: STAGE_SEQ_PERF_CNT_EN enables the cycle and
// instruction performance counters (otherwise both outputs read 0).

package stage_sequencer_pkg;
  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_IF       = 4'd1,
    S_IF_WAIT  = 4'd2,
    S_ID       = 4'd3,
    S_EX       = 4'd4,
    S_MEM      = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_WB       = 4'd7,
    S_HALT     = 4'd8
  } state_e;
endpackage

module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int IF_LAT  = 1,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             resume,
  output logic             pc_wren,
  output logic             wb_if_wren,
  output logic             if_id_wren,
  output logic             id_ex_wren,
  output logic             ex_mem_wren,
  output logic             mem_wb_wren,
  output logic             ram_wren,
  output logic             reg_wren,
  output logic             stage_reset_n,
  output logic [3:0]       stage,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // Wait counters load "latency - 1" so the final dwell cycle sees zero.
  localparam logic [3:0] IF_LOAD  = 4'(IF_LAT - 1);
  localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  // State and wait-counter registers; reset forces INIT immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic plus Moore output decode (state and wait counter only).
  always_comb begin
    state_d       = S_INIT;
    wait_d        = '0;
    pc_wren       = 1'b0;
    wb_if_wren    = 1'b0;
    if_id_wren    = 1'b0;
    id_ex_wren    = 1'b0;
    ex_mem_wren   = 1'b0;
    mem_wb_wren   = 1'b0;
    ram_wren      = 1'b0;
    reg_wren      = 1'b0;
    stage_reset_n = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        state_d       = S_IF_WAIT;
        wait_d        = IF_LOAD;
        stage_reset_n = 1'b1;
      end
      S_IF_WAIT: begin
        stage_reset_n = 1'b1;
        if (wait_q == 4'd0) begin
          state_d    = S_ID;
          if_id_wren = 1'b1;
        end else begin
          state_d = S_IF_WAIT;
          wait_d  = wait_q - 4'd1;
        end
      end
      S_ID: begin
        state_d       = S_EX;
        stage_reset_n = 1'b1;
        id_ex_wren    = 1'b1;
      end
      S_EX: begin
        state_d       = S_MEM;
        stage_reset_n = 1'b1;
        ex_mem_wren   = 1'b1;
      end
      S_MEM: begin
        state_d       = S_MEM_WAIT;
        wait_d        = MEM_LOAD;
        stage_reset_n = 1'b1;
        pc_wren       = 1'b1;
        ram_wren      = 1'b1;
      end
      S_MEM_WAIT: begin
        stage_reset_n = 1'b1;
        if (wait_q == 4'd0) begin
          state_d     = S_WB;
          mem_wb_wren = 1'b1;
        end else begin
          state_d = S_MEM_WAIT;
          wait_d  = wait_q - 4'd1;
        end
      end
      S_WB: begin
        state_d    = halt ? S_HALT : S_IF;
        wb_if_wren = 1'b1;
        reg_wren   = 1'b1;
      end
      S_HALT: begin
        state_d = resume ? S_IF : S_HALT;
        halted  = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign stage = state_q;

`ifdef STAGE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  // Perf counters: active cycles outside INIT/HALT, and retired instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != S_INIT && state_q != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (state_q == S_WB) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: two instances (latencies 1/1 and
// 3/4), scoreboard of expected per-cycle stage/enable vectors.
module tb_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, halt, resume, reset2, halt2, resume2;

  logic a_pc, a_wbif, a_ifid, a_idex, a_exmem, a_memwb, a_ram, a_reg, a_srn, a_hl;
  logic [3:0] a_stage;
  logic [31:0] a_cyc, a_ins;
  logic b_pc, b_wbif, b_ifid, b_idex, b_exmem, b_memwb, b_ram, b_reg, b_srn, b_hl;
  logic [3:0] b_stage;
  logic [31:0] b_cyc, b_ins;

  stage_sequencer #(.IF_LAT(1), .MEM_LAT(1), .CNT_W(32)) u_seq1 (
    .clk(clk), .reset(reset), .halt(halt), .resume(resume),
    .pc_wren(a_pc), .wb_if_wren(a_wbif), .if_id_wren(a_ifid), .id_ex_wren(a_idex),
    .ex_mem_wren(a_exmem), .mem_wb_wren(a_memwb), .ram_wren(a_ram), .reg_wren(a_reg),
    .stage_reset_n(a_srn), .stage(a_stage), .halted(a_hl),
    .cycle_cnt(a_cyc), .instr_cnt(a_ins)
  );

  stage_sequencer #(.IF_LAT(3), .MEM_LAT(4), .CNT_W(32)) u_seq2 (
    .clk(clk), .reset(reset2), .halt(halt2), .resume(resume2),
    .pc_wren(b_pc), .wb_if_wren(b_wbif), .if_id_wren(b_ifid), .id_ex_wren(b_idex),
    .ex_mem_wren(b_exmem), .mem_wb_wren(b_memwb), .ram_wren(b_ram), .reg_wren(b_reg),
    .stage_reset_n(b_srn), .stage(b_stage), .halted(b_hl),
    .cycle_cnt(b_cyc), .instr_cnt(b_ins)
  );

  // Expected vector: stage, {pc,wb_if,if_id,id_ex,ex_mem,mem_wb,ram,reg}, stage_reset_n, halted
  typedef struct packed {
    logic [3:0] st;
    logic [7:0] wr;
    logic       srn;
    logic       hl;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t obs(input int s);
    exp_t o;
    if (s == 1) o = '{a_stage, {a_pc, a_wbif, a_ifid, a_idex, a_exmem, a_memwb, a_ram, a_reg}, a_srn, a_hl};
    else        o = '{b_stage, {b_pc, b_wbif, b_ifid, b_idex, b_exmem, b_memwb, b_ram, b_reg}, b_srn, b_hl};
    return o;
  endfunction

  task automatic push(input logic [3:0] st, input logic [7:0] wr, input logic srn, input logic hl);
    exp_t e;
    e = '{st, wr, srn, hl};
    sb.push_back(e);
  endtask

  // One instruction from IF through WB with the given dwell latencies.
  task automatic push_instr(input int il, input int ml);
    push(4'd1, 8'b0000_0000, 1'b1, 1'b0);
    for (int i = 0; i < il; i++) push(4'd2, (i == il - 1) ? 8'b0010_0000 : 8'b0, 1'b1, 1'b0);
    push(4'd3, 8'b0001_0000, 1'b1, 1'b0);
    push(4'd4, 8'b0000_1000, 1'b1, 1'b0);
    push(4'd5, 8'b1000_0010, 1'b1, 1'b0);
    for (int i = 0; i < ml; i++) push(4'd6, (i == ml - 1) ? 8'b0000_0100 : 8'b0, 1'b1, 1'b0);
    push(4'd7, 8'b0100_0001, 1'b0, 1'b0);
  endtask

  task automatic check(input string tag, input int s);
    exp_t e, o;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      o = obs(s);
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s: got stage=%0d wr=%b srn=%b halted=%b, want stage=%0d wr=%b srn=%b halted=%b",
               tag, o.st, o.wr, o.srn, o.hl, e.st, e.wr, e.srn, e.hl);
      end
    end
  endtask

  task automatic cmpv(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endtask

  // Advance n cycles, comparing each cycle's output just after the edge.
  task automatic cyc(input int n, input int s, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      check(tag, s);
    end
  endtask

`ifdef STAGE_SEQ_PERF_CNT_EN
  localparam logic [31:0] EXP_CYC = 32'd70;
  localparam logic [31:0] EXP_INS = 32'd10;
`else
  localparam logic [31:0] EXP_CYC = 32'd0;
  localparam logic [31:0] EXP_INS = 32'd0;
`endif

  initial begin
    reset = 1'b1; halt = 1'b0; resume = 1'b0;
    reset2 = 1'b1; halt2 = 1'b0; resume2 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    push(4'd0, 8'b0, 1'b0, 1'b0);
    check("reset_state", 1);
    cmpv("reset_cycle_cnt", a_cyc, 32'd0);
    cmpv("reset_instr_cnt", a_ins, 32'd0);

    // Release: INIT until the first edge, then IF
    @(negedge clk);
    reset = 1'b0;
    #1;
    push(4'd0, 8'b0, 1'b0, 1'b0);
    check("release_init", 1);

    // Ten instructions at latency 1/1, halt requested in the tenth WB
    for (int k = 0; k < 10; k++) push_instr(1, 1);
    cyc(70, 1, "run_lat11");
    halt = 1'b1;
    push(4'd8, 8'b0, 1'b0, 1'b1);
    cyc(1, 1, "enter_halt");
    cmpv("halt_cycle_cnt", a_cyc, EXP_CYC);
    cmpv("halt_instr_cnt", a_ins, EXP_INS);

    // Stay in HALT while resume is low
    repeat (5) push(4'd8, 8'b0, 1'b0, 1'b1);
    cyc(5, 1, "hold_halt");
    cmpv("frozen_cycle_cnt", a_cyc, EXP_CYC);
    cmpv("frozen_instr_cnt", a_ins, EXP_INS);

    // resume wins over halt in HALT; resume stays high outside HALT (ignored)
    resume = 1'b1;
    push(4'd1, 8'b0, 1'b1, 1'b0);
    cyc(1, 1, "resume");
    halt = 1'b0;
    push(4'd2, 8'b0010_0000, 1'b1, 1'b0);
    push(4'd3, 8'b0001_0000, 1'b1, 1'b0);
    push(4'd4, 8'b0000_1000, 1'b1, 1'b0);
    push(4'd5, 8'b1000_0010, 1'b1, 1'b0);
    cyc(4, 1, "after_resume");
    resume = 1'b0;

    // Asynchronous reset between edges while in MEM
    #2;
    reset = 1'b1;
    #1;
    push(4'd0, 8'b0, 1'b0, 1'b0);
    check("async_reset_mem", 1);
    cmpv("async_reset_cycle_cnt", a_cyc, 32'd0);
    cmpv("async_reset_instr_cnt", a_ins, 32'd0);
    push(4'd0, 8'b0, 1'b0, 1'b0);
    cyc(1, 1, "reset_held");
    @(negedge clk);
    reset = 1'b0;
    #1;
    push(4'd0, 8'b0, 1'b0, 1'b0);
    check("rerelease_init", 1);
    push(4'd1, 8'b0, 1'b1, 1'b0);
    push(4'd2, 8'b0010_0000, 1'b1, 1'b0);
    push(4'd3, 8'b0001_0000, 1'b1, 1'b0);
    cyc(3, 1, "restart");

    // Illegal state code recovers through INIT
    @(negedge clk);
    force u_seq1.state_q = stage_sequencer_pkg::state_e'(4'd12);
    #1;
    release u_seq1.state_q;
    push(4'd0, 8'b0, 1'b0, 1'b0);
    push(4'd1, 8'b0, 1'b1, 1'b0);
    cyc(2, 1, "illegal_recover");

    // Latency 3/4 instance: period 12
    @(negedge clk);
    reset2 = 1'b0;
    #1;
    push(4'd0, 8'b0, 1'b0, 1'b0);
    check("lat34_init", 2);
    push_instr(3, 4);
    push_instr(3, 4);
    cyc(24, 2, "run_lat34");

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
